// File: rtl/ex_pkg.sv
// ex_pkg: shared types and constants for the ex_mc execute stage.
//   - aluop_e     : 8-bit operation codes presented on aluop_i
//   - alusel_e    : 3-bit result class select presented on alusel_i
//   - div_state_e : iterative divider FSM states
//   - ZERO_WORD   : all-zero constant, sliced to the operand width by users
//                   (wide enough for any DATA_W up to 64)
package ex_pkg;

    typedef enum logic [7:0] {
        OP_AND  = 8'b0010_0100,
        OP_OR   = 8'b0010_0101,
        OP_XOR  = 8'b0010_0110,
        OP_NOR  = 8'b0010_0111,
        OP_SLL  = 8'b0111_1100,
        OP_SRL  = 8'b0000_0010,
        OP_SRA  = 8'b0000_0011,
        OP_ADD  = 8'b0010_0000,
        OP_ADDU = 8'b0010_0001,
        OP_SUB  = 8'b0010_0010,
        OP_SUBU = 8'b0010_0011,
        OP_SLT  = 8'b0010_1010,
        OP_SLTU = 8'b0010_1011,
        OP_DIV  = 8'b0001_1010,
        OP_DIVU = 8'b0001_1011
    } aluop_e;

    typedef enum logic [2:0] {
        SEL_NOP   = 3'b000,
        SEL_LOGIC = 3'b001,
        SEL_SHIFT = 3'b010,
        SEL_ARITH = 3'b100
    } alusel_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

    localparam logic [63:0] ZERO_WORD = 64'h0;

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative radix-2 restoring divider with stall handshake.
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   start_i           a DIV or DIVU is presented this cycle
//   signed_i          treat operands as two's complement (DIV)
//   reg1_i, reg2_i    dividend / divisor, sampled only when leaving IDLE
//   annul_i           flush: back to IDLE next edge, masks stall/whilo now
//   stallreq_o        hold the upstream pipeline
//   whilo_o           HI/LO write strobe (END state only)
//   hi_o, lo_o        remainder / quotient, valid while whilo_o is high
module ex_div
    import ex_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              annul_i,
    output logic              stallreq_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ZERO_W = ZERO_WORD[DATA_W-1:0];

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;     // partial remainder
    logic [DATA_W-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0] dvsr_q, dvsr_d;   // divisor magnitude
    logic              negq_q, negq_d;   // negate quotient at END
    logic              negr_q, negr_d;   // negate remainder at END

    logic [DATA_W-1:0] mag1_s, mag2_s;
    logic [DATA_W:0]   trial_s, diff_s;
    logic              stall_s, whilo_s;
    logic [DATA_W-1:0] hi_s, lo_s;

    // Operand magnitudes and the current restoring trial subtraction.
    always_comb begin
        mag1_s  = (signed_i && reg1_i[DATA_W-1]) ? (ZERO_W - reg1_i) : reg1_i;
        mag2_s  = (signed_i && reg2_i[DATA_W-1]) ? (ZERO_W - reg2_i) : reg2_i;
        trial_s = {rem_q, quo_q[DATA_W-1]};
        diff_s  = trial_s - {1'b0, dvsr_q};
    end

    // Next-state, datapath update and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        stall_s = 1'b0;
        whilo_s = 1'b0;
        hi_s    = ZERO_W;
        lo_s    = ZERO_W;

        case (state_q)
            DIV_IDLE: begin
                if (start_i) begin
                    stall_s = 1'b1;
                    if (reg2_i == ZERO_W) begin
                        // Divide by zero reuses the END path: hi = raw dividend.
                        state_d = DIV_ZERO;
                        rem_d   = reg1_i;
                        quo_d   = ~ZERO_W;
                        negq_d  = 1'b0;
                        negr_d  = 1'b0;
                    end else begin
                        state_d = DIV_ON;
                        cnt_d   = {CNT_W{1'b0}};
                        rem_d   = ZERO_W;
                        quo_d   = mag1_s;
                        dvsr_d  = mag2_s;
                        negq_d  = signed_i && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        negr_d  = signed_i && reg1_i[DATA_W-1];
                    end
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_ZERO: begin
                stall_s = 1'b1;
                state_d = DIV_END;
            end
            DIV_ON: begin
                stall_s = 1'b1;
                if (!diff_s[DATA_W]) begin
                    rem_d = diff_s[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = trial_s[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
                    state_d = DIV_END;
                end else begin
                    state_d = DIV_ON;
                end
            end
            DIV_END: begin
                whilo_s = 1'b1;
                lo_s    = negq_q ? (ZERO_W - quo_q) : quo_q;
                hi_s    = negr_q ? (ZERO_W - rem_q) : rem_q;
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        // Flush wins over everything, including a division detected this cycle.
        if (annul_i) begin
            state_d = DIV_IDLE;
            stall_s = 1'b0;
            whilo_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            rem_q   <= ZERO_W;
            quo_q   <= ZERO_W;
            dvsr_q  <= ZERO_W;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign stallreq_o = stall_s;
    assign whilo_o    = whilo_s;
    assign hi_o       = hi_s;
    assign lo_o       = lo_s;

endmodule

// File: rtl/ex_mc.sv
// ex_mc: multi-cycle execute stage.
// Logic/shift/arith results are combinational; DIV/DIVU run on ex_div and
// stall the pipeline until HI/LO is written.
// Build option: define EX_DIV_EN to include the divider; without it DIV/DIVU
// are no-ops and stallreq_o, whilo_o, hi_o, lo_o are tied low.
// Ports:
//   clk, rst            clock / synchronous active-high reset (all outputs 0 in reset)
//   aluop_i, alusel_i   operation and result class (ex_pkg codes)
//   reg1_i, reg2_i      operands
//   wd_i, wreg_i        destination register and write enable
//   annul_i             flush, cancels an in-flight division
//   wdata_o, wd_o, wreg_o   GPR write port
//   hi_o, lo_o, whilo_o     HI/LO write port (remainder, quotient)
//   stallreq_o              stall request to the hazard controller
module ex_mc
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              stallreq_o
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [DATA_W-1:0] ZERO_W = ZERO_WORD[DATA_W-1:0];

    aluop_e            op_s;
    alusel_e           sel_s;
    logic [SH_W-1:0]   shamt_s;
    logic [DATA_W-1:0] logic_res_s, shift_res_s, arith_res_s, wdata_s;
    logic [DATA_W-1:0] b_eff_s, sum_s;
    logic              sub_s, ovf_s;
    logic              div_stall_s, div_whilo_s;
    logic [DATA_W-1:0] div_hi_s, div_lo_s;

    assign op_s    = aluop_e'(aluop_i);
    assign sel_s   = alusel_e'(alusel_i);
    assign shamt_s = reg1_i[SH_W-1:0];

    // Logic unit.
    always_comb begin
        logic_res_s = ZERO_W;
        case (op_s)
            OP_AND:  logic_res_s = reg1_i & reg2_i;
            OP_OR:   logic_res_s = reg1_i | reg2_i;
            OP_XOR:  logic_res_s = reg1_i ^ reg2_i;
            OP_NOR:  logic_res_s = ~(reg1_i | reg2_i);
            default: logic_res_s = ZERO_W;
        endcase
    end

    // Shifter: reg2_i is shifted by the low bits of reg1_i.
    always_comb begin
        shift_res_s = ZERO_W;
        case (op_s)
            OP_SLL:  shift_res_s = reg2_i << shamt_s;
            OP_SRL:  shift_res_s = reg2_i >> shamt_s;
            OP_SRA:  shift_res_s = DATA_W'($signed(reg2_i) >>> shamt_s);
            default: shift_res_s = ZERO_W;
        endcase
    end

    // Adder shared by add and subtract; subtract adds ~b + 1.
    always_comb begin
        sub_s   = (op_s == OP_SUB) || (op_s == OP_SUBU);
        b_eff_s = sub_s ? ~reg2_i : reg2_i;
        sum_s   = reg1_i + b_eff_s + {ZERO_W[DATA_W-1:1], sub_s};
        // Signed overflow: same-sign effective operands, result sign flipped.
        ovf_s   = ((op_s == OP_ADD) || (op_s == OP_SUB)) &&
                  (reg1_i[DATA_W-1] == b_eff_s[DATA_W-1]) &&
                  (sum_s[DATA_W-1] != reg1_i[DATA_W-1]);
    end

    // Arithmetic result select.
    always_comb begin
        arith_res_s = ZERO_W;
        case (op_s)
            OP_ADD, OP_ADDU, OP_SUB, OP_SUBU: arith_res_s = sum_s;
            OP_SLT:  arith_res_s = {ZERO_W[DATA_W-1:1], ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLTU: arith_res_s = {ZERO_W[DATA_W-1:1], (reg1_i < reg2_i)};
            default: arith_res_s = ZERO_W;
        endcase
    end

    // Result class multiplexer.
    always_comb begin
        wdata_s = ZERO_W;
        case (sel_s)
            SEL_LOGIC: wdata_s = logic_res_s;
            SEL_SHIFT: wdata_s = shift_res_s;
            SEL_ARITH: wdata_s = arith_res_s;
            default:   wdata_s = ZERO_W;
        endcase
    end

`ifdef EX_DIV_EN
    logic div_start_s, div_signed_s;

    assign div_start_s  = (op_s == OP_DIV) || (op_s == OP_DIVU);
    assign div_signed_s = (op_s == OP_DIV);

    ex_div #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start_s),
        .signed_i   (div_signed_s),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .annul_i    (annul_i),
        .stallreq_o (div_stall_s),
        .whilo_o    (div_whilo_s),
        .hi_o       (div_hi_s),
        .lo_o       (div_lo_s)
    );
`else
    logic unused_div_s;

    assign unused_div_s = clk ^ annul_i;
    assign div_stall_s  = 1'b0;
    assign div_whilo_s  = 1'b0;
    assign div_hi_s     = ZERO_W;
    assign div_lo_s     = ZERO_W;
`endif

    // Output stage: everything is held at zero while in reset.
    always_comb begin
        if (rst) begin
            wdata_o    = ZERO_W;
            wd_o       = {ADDR_W{1'b0}};
            wreg_o     = 1'b0;
            hi_o       = ZERO_W;
            lo_o       = ZERO_W;
            whilo_o    = 1'b0;
            stallreq_o = 1'b0;
        end else begin
            wdata_o    = wdata_s;
            wd_o       = wd_i;
            wreg_o     = wreg_i & ~ovf_s;
            hi_o       = div_hi_s;
            lo_o       = div_lo_s;
            whilo_o    = div_whilo_s;
            stallreq_o = div_stall_s;
        end
    end

endmodule

// File: tb/tb_ex_mc.sv
// tb_ex_mc: directed-vector bench for ex_mc with a cycle-tagged scoreboard.
// Stimulus pushes the expected per-cycle outputs (and expected HI/LO writes);
// a negedge monitor pops and compares independently.
module tb_ex_mc;
    import ex_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int S_WDATA = 0;
    localparam int S_WREG  = 1;
    localparam int S_STALL = 2;
    localparam int S_WHILO = 3;
    localparam int S_WD    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    aluop_i;
    logic [2:0]    alusel_i;
    logic [DW-1:0] reg1_i, reg2_i;
    logic [AW-1:0] wd_i;
    logic          wreg_i, annul_i;
    logic [DW-1:0] wdata_o, hi_o, lo_o;
    logic [AW-1:0] wd_o;
    logic          wreg_o, whilo_o, stallreq_o;

    ex_mc #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .annul_i    (annul_i),
        .wdata_o    (wdata_o),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .whilo_o    (whilo_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } hilo_t;

    exp_t  exp_q[$];
    hilo_t hilo_q[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            S_WDATA: return wdata_o;
            S_WREG:  return {31'd0, wreg_o};
            S_STALL: return {31'd0, stallreq_o};
            S_WHILO: return {31'd0, whilo_o};
            S_WD:    return {27'd0, wd_o};
            default: return 32'd0;
        endcase
    endfunction

    // Monitor: compare every expectation tagged for this cycle, and every HI/LO write.
    exp_t        m_e;
    hilo_t       m_h;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            m_e   = exp_q.pop_front();
            m_act = actual(m_e.sel);
            n_vec = n_vec + 1;
            if (m_e.cyc != cyc || m_act !== m_e.val) begin
                n_err = n_err + 1;
                $display("FAIL %s @cyc %0d: got %h, expected %h", m_e.name, m_e.cyc, m_act, m_e.val);
            end
        end
        if (whilo_o === 1'b1) begin
            if (hilo_q.size() == 0) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_whilo @cyc %0d: hi %h lo %h", cyc, hi_o, lo_o);
            end else begin
                m_h   = hilo_q.pop_front();
                n_vec = n_vec + 2;
                if (hi_o !== m_h.hi) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_hi: got %h, expected %h", m_h.name, hi_o, m_h.hi);
                end
                if (lo_o !== m_h.lo) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_lo: got %h, expected %h", m_h.name, lo_o, m_h.lo);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(int sel, logic [31:0] val, string name);
        exp_t e;
        e.cyc  = cyc;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic apply(aluop_e op, alusel_e sel, logic [31:0] r1, logic [31:0] r2,
                         logic [4:0] wd, logic wr);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = r1;
        reg2_i   = r2;
        wd_i     = wd;
        wreg_i   = wr;
    endtask

    // One combinational ALU vector: check data, write enable, stall, destination.
    task automatic alu_vec(aluop_e op, alusel_e sel, logic [31:0] r1, logic [31:0] r2,
                           logic wr, logic [31:0] exp_data, logic exp_wreg, string name);
        apply(op, sel, r1, r2, 5'd9, wr);
        expect_o(S_WDATA, exp_data, {name, "_wdata"});
        expect_o(S_WREG, {31'd0, exp_wreg}, {name, "_wreg"});
        expect_o(S_STALL, 32'd0, {name, "_stall"});
        expect_o(S_WD, 32'd9, {name, "_wd"});
        step();
    endtask

`ifdef EX_DIV_EN
    // Full division: stall for nstall cycles, then one END cycle with the write.
    task automatic div_run(aluop_e op, logic [31:0] r1, logic [31:0] r2, int nstall,
                           logic [31:0] exp_hi, logic [31:0] exp_lo, string name);
        hilo_t h;
        h.hi = exp_hi;
        h.lo = exp_lo;
        h.name = name;
        hilo_q.push_back(h);
        apply(op, SEL_NOP, r1, r2, 5'd0, 1'b0);
        for (int k = 0; k <= nstall; k++) begin
            expect_o(S_STALL, {31'd0, (k < nstall)}, {name, "_stall"});
            expect_o(S_WHILO, {31'd0, (k == nstall)}, {name, "_whilo"});
            step();
        end
    endtask

    // Division cut short at cycle 10 by annul (use_rst=0) or reset (use_rst=1).
    task automatic div_abort(logic use_rst, string name);
        apply(OP_DIVU, SEL_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            expect_o(S_STALL, 32'd1, {name, "_stall_pre"});
            step();
        end
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        expect_o(S_STALL, 32'd0, {name, "_stall_cut"});
        expect_o(S_WHILO, 32'd0, {name, "_whilo_cut"});
        step();
        rst     = 1'b0;
        annul_i = 1'b0;
        apply(OP_OR, SEL_LOGIC, 32'd1, 32'd2, 5'd3, 1'b1);
        for (int k = 0; k < 40; k++) begin
            expect_o(S_STALL, 32'd0, {name, "_stall_post"});
            expect_o(S_WHILO, 32'd0, {name, "_whilo_post"});
            step();
        end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        annul_i = 1'b0;
        apply(OP_OR, SEL_LOGIC, 32'h1234_5678, 32'h0F0F_0000, 5'd7, 1'b1);
        step();
        // Reset holds every output at zero even with live inputs.
        for (int k = 0; k < 2; k++) begin
            expect_o(S_WDATA, 32'd0, "rst_wdata");
            expect_o(S_WREG, 32'd0, "rst_wreg");
            expect_o(S_STALL, 32'd0, "rst_stall");
            expect_o(S_WHILO, 32'd0, "rst_whilo");
            expect_o(S_WD, 32'd0, "rst_wd");
            step();
        end
        rst = 1'b0;

        alu_vec(OP_OR,   SEL_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000, 1'b1, 32'h0F0F_F0F0, 1'b1, "or");
        alu_vec(OP_AND,  SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1, 32'h0F00_0F00, 1'b1, "and");
        alu_vec(OP_XOR,  SEL_LOGIC, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 32'hF0F0_F0F0, 1'b0, "xor");
        alu_vec(OP_NOR,  SEL_LOGIC, 32'hFF00_0000, 32'h0000_00FF, 1'b1, 32'h00FF_FF00, 1'b1, "nor");
        alu_vec(OP_SRA,  SEL_SHIFT, 32'd4,         32'h8000_0000, 1'b1, 32'hF800_0000, 1'b1, "sra");
        alu_vec(OP_SRL,  SEL_SHIFT, 32'd31,        32'h8000_0000, 1'b1, 32'h0000_0001, 1'b1, "srl31");
        alu_vec(OP_SLL,  SEL_SHIFT, 32'd36,        32'h0000_0001, 1'b1, 32'h0000_0010, 1'b1, "sll_mask");
        alu_vec(OP_ADD,  SEL_ARITH, 32'h7FFF_FFFF, 32'd1,         1'b1, 32'h8000_0000, 1'b0, "add_ovf");
        alu_vec(OP_ADDU, SEL_ARITH, 32'h7FFF_FFFF, 32'd1,         1'b1, 32'h8000_0000, 1'b1, "addu");
        alu_vec(OP_ADD,  SEL_ARITH, 32'hFFFF_FFFF, 32'd5,         1'b1, 32'h0000_0004, 1'b1, "add_ok");
        alu_vec(OP_SUB,  SEL_ARITH, 32'h8000_0000, 32'd1,         1'b1, 32'h7FFF_FFFF, 1'b0, "sub_ovf");
        alu_vec(OP_SUBU, SEL_ARITH, 32'd3,         32'd5,         1'b1, 32'hFFFF_FFFE, 1'b1, "subu");
        alu_vec(OP_SLT,  SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'd1,         1'b1, "slt");
        alu_vec(OP_SLTU, SEL_ARITH, 32'hFFFF_FFFF, 32'd1,         1'b1, 32'd0,         1'b1, "sltu");
        alu_vec(OP_AND,  SEL_NOP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'd0,         1'b1, "sel_nop");

`ifdef EX_DIV_EN
        div_run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        // Second divide presented straight after END is picked up in IDLE.
        div_run(OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu_b2b");
        div_run(OP_DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF, "divu_by0");
        div_run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0, 32'h8000_0000, "div_min");
        div_abort(1'b0, "annul");
        div_abort(1'b1, "rst");
        div_run(OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14, "divu_after_rst");
`else
        // Without the divider, DIV/DIVU never stall or write HI/LO.
        for (int k = 0; k < 4; k++) begin
            apply(OP_DIV, SEL_NOP, 32'd100, 32'd7, 5'd2, 1'b1);
            expect_o(S_STALL, 32'd0, "nodiv_stall");
            expect_o(S_WHILO, 32'd0, "nodiv_whilo");
            expect_o(S_WREG, 32'd1, "nodiv_wreg");
            step();
        end
`endif

        apply(OP_OR, SEL_LOGIC, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int k = 0; k < 40 && (exp_q.size() > 0 || hilo_q.size() > 0); k++) step();
        step();
        if (exp_q.size() > 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL unchecked_expectations: %0d left, expected 0", exp_q.size());
        end
        if (hilo_q.size() > 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL missing_whilo: %0d writes outstanding, expected 0", hilo_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

endmodule
